// File: rtl/arm_sram_pkg.sv
// Shared definitions for the SRAM port arbiter: FSM encoding, timing default,
// SRAM geometry and the grant-selection helper.
package arm_sram_pkg;

  // Default number of cycles each 16-bit SRAM phase is held.
  localparam int unsigned WaitCyclesDefault = 2;

  // SRAM half-word address width.
  localparam int unsigned SramAddrWidth = 18;

  // Width of the wait counter; covers the full 1..15 WAIT_CYCLES range.
  localparam int unsigned WaitCntWidth = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLo   = 2'd1,
    StHi   = 2'd2,
    StDone = 2'd3
  } arb_state_e;

  // Returns 1 when the fetch port (m1) should win this arbitration round.
  // prefer_m1 breaks a tie; a lone requester always wins.
  function automatic logic grant_m1(input logic req0, input logic req1, input logic prefer_m1);
    return req1 && (!req0 || prefer_m1);
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Down-counter that times each SRAM phase. Loading value N makes the
// terminal-count output rise after N enabled cycles.
module sram_wait_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [Width-1:0] load_value,
  output logic             tc
);

  logic [Width-1:0] count_q;

  // Load takes priority over counting; the count parks at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign tc = (count_q == '0);

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter in front of a 16-bit asynchronous SRAM. Each 32-bit access
// is split into a low and a high half-word phase, each WAIT_CYCLES long.
// Port m0 (data) may read or write; port m1 (instruction fetch) only reads.
// Arbitration is fixed m0 priority by default; defining ARB_ROUND_ROBIN_EN
// switches ties to alternate between the ports.
module sram_port_arbiter
  import arm_sram_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = WaitCyclesDefault
) (
  input  logic                     clk,
  input  logic                     rst,
  // Data (MEM-stage) port
  input  logic                     m0_req,
  input  logic                     m0_we,
  input  logic [31:0]              m0_addr,
  input  logic [31:0]              m0_wdata,
  output logic [31:0]              m0_rdata,
  output logic                     m0_ready,
  // Instruction-fetch port, read-only
  input  logic                     m1_req,
  input  logic [31:0]              m1_addr,
  output logic [31:0]              m1_rdata,
  output logic                     m1_ready,
  // SRAM pins
  inout  wire  [15:0]              SRAM_DQ,
  output logic [SramAddrWidth-1:0] SRAM_ADDR,
  output logic                     SRAM_WE_N,
  output logic                     SRAM_CE_N,
  output logic                     SRAM_OE_N,
  output logic                     SRAM_UB_N,
  output logic                     SRAM_LB_N
);

  localparam logic [WaitCntWidth-1:0] WaitLoad = WaitCntWidth'(WAIT_CYCLES - 1);

  arb_state_e                 state_q;
  logic                       grant_q;  // 1: m1 owns the current transaction
  logic                       we_q;
  logic [SramAddrWidth-2:0]   addr_q;   // word address, addr[18:2]
  logic [31:0]                wdata_q;
  logic [31:0]                rd_buf_q;
  logic [31:0]                m0_rdata_q;
  logic [31:0]                m1_rdata_q;
  logic                       m0_ready_q;
  logic                       m1_ready_q;
  logic [SramAddrWidth-1:0]   sram_addr_q;
  logic                       we_n_q;
  logic                       dq_oe;
  logic [15:0]                dq_out_q;

  logic                       any_req;
  logic                       pick_m1;
  logic                       prefer_m1;
  logic                       cnt_load;
  logic                       cnt_en;
  logic                       cnt_tc;

`ifdef ARB_ROUND_ROBIN_EN
  logic                       last_m1_q;  // 1: m1 was served last

  // Remember which port was granted so the other one wins the next tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_m1_q <= 1'b0;
    end else if ((state_q == StIdle) && any_req) begin
      last_m1_q <= pick_m1;
    end
  end

  assign prefer_m1 = !last_m1_q;
`else
  assign prefer_m1 = 1'b0;
`endif

  // Arbitration and phase-timer control derived from the current state.
  always_comb begin
    any_req  = m0_req || m1_req;
    pick_m1  = grant_m1(m0_req, m1_req, prefer_m1);
    cnt_load = ((state_q == StIdle) && any_req) ||
               (((state_q == StLo)) && cnt_tc);
    cnt_en   = (state_q == StLo) || (state_q == StHi);
  end

  sram_wait_counter #(
    .Width (WaitCntWidth)
  ) u_wait_counter (
    .clk        (clk),
    .rst        (rst),
    .load       (cnt_load),
    .en         (cnt_en),
    .load_value (WaitLoad),
    .tc         (cnt_tc)
  );

  // Transaction FSM; every SRAM strobe and port output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      grant_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_buf_q    <= '0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      m0_ready_q  <= 1'b0;
      m1_ready_q  <= 1'b0;
      sram_addr_q <= '0;
      we_n_q      <= 1'b1;
      dq_oe       <= 1'b0;
      dq_out_q    <= '0;
    end else begin
      m0_ready_q <= 1'b0;
      m1_ready_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (any_req) begin
            // Latch the winner; port inputs are ignored until completion.
            grant_q     <= pick_m1;
            we_q        <= pick_m1 ? 1'b0 : m0_we;
            addr_q      <= pick_m1 ? m1_addr[18:2] : m0_addr[18:2];
            wdata_q     <= m0_wdata;
            sram_addr_q <= {(pick_m1 ? m1_addr[18:2] : m0_addr[18:2]), 1'b0};
            we_n_q      <= pick_m1 ? 1'b1 : !m0_we;
            dq_oe       <= pick_m1 ? 1'b0 : m0_we;
            dq_out_q    <= m0_wdata[15:0];
            state_q     <= StLo;
          end
        end
        StLo: begin
          if (cnt_tc) begin
            if (!we_q) begin
              rd_buf_q[15:0] <= SRAM_DQ;
            end
            sram_addr_q <= {addr_q, 1'b1};
            dq_out_q    <= wdata_q[31:16];
            state_q     <= StHi;
          end
        end
        StHi: begin
          if (cnt_tc) begin
            if (!we_q) begin
              rd_buf_q[31:16] <= SRAM_DQ;
            end
            we_n_q  <= 1'b1;
            dq_oe   <= 1'b0;
            state_q <= StDone;
          end
        end
        StDone: begin
          if (grant_q) begin
            m1_ready_q <= 1'b1;
            m1_rdata_q <= rd_buf_q;
          end else begin
            m0_ready_q <= 1'b1;
            if (!we_q) begin
              m0_rdata_q <= rd_buf_q;
            end
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Only the word-address bits reach the SRAM.
  logic unused_addr;
  assign unused_addr = ^{m0_addr[31:19], m0_addr[1:0], m1_addr[31:19], m1_addr[1:0]};

  assign SRAM_DQ   = dq_oe ? dq_out_q : 16'hzzzz;
  assign SRAM_ADDR = sram_addr_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign m0_ready  = m0_ready_q;
  assign m1_ready  = m1_ready_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural SRAM and a
// scoreboard of expected completions (port, data, cycle).
module tb_sram_port_arbiter;

  localparam int W   = 2;
  localparam int LAT = 2 * W + 2;  // from the cycle the request is driven

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req;
  logic [31:0] m0_addr, m0_wdata, m1_addr;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ready, m1_ready;
  wire  [15:0] SRAM_DQ;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_WE_N, SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    bit          port;
    bit          chk_data;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  logic [15:0] mem [0:1023];

  sram_port_arbiter #(
    .WAIT_CYCLES (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_rdata  (m0_rdata),
    .m0_ready  (m0_ready),
    .m1_req    (m1_req),
    .m1_addr   (m1_addr),
    .m1_rdata  (m1_rdata),
    .m1_ready  (m1_ready),
    .SRAM_DQ   (SRAM_DQ),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_WE_N (SRAM_WE_N),
    .SRAM_CE_N (SRAM_CE_N),
    .SRAM_OE_N (SRAM_OE_N),
    .SRAM_UB_N (SRAM_UB_N),
    .SRAM_LB_N (SRAM_LB_N)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural asynchronous SRAM: drives on read, captures on write.
  assign SRAM_DQ = (SRAM_WE_N && !SRAM_OE_N) ? mem[SRAM_ADDR[9:0]] : 16'hzzzz;
  always @(posedge clk) if (!SRAM_WE_N) mem[SRAM_ADDR[9:0]] <= SRAM_DQ;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit port, input bit chk_data, input logic [31:0] data);
    exp_t e;
    e.port = port;
    e.chk_data = chk_data;
    e.data = data;
    e.cyc = cyc + LAT;
    sb.push_back(e);
  endtask

  // Completion monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (m0_ready && m1_ready) check("both_ready", 32'd1, 32'd0);
      if (m0_ready || m1_ready) begin
        check("unexpected_ready", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("ready_port", {31'd0, m1_ready}, {31'd0, e.port});
          check("ready_cycle", cyc, e.cyc);
          if (e.chk_data) check("rdata", e.port ? m1_rdata : m0_rdata, e.data);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'hA000 + 16'(i);
    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_addr = 0;
    tick();
    tick();
    // Reset state
    check("rst_m0_ready", {31'd0, m0_ready}, 32'd0);
    check("rst_m1_ready", {31'd0, m1_ready}, 32'd0);
    check("rst_m0_rdata", m0_rdata, 32'd0);
    check("rst_m1_rdata", m1_rdata, 32'd0);
    check("rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
    check("rst_addr", {14'd0, SRAM_ADDR}, 32'd0);
    check("rst_dq_oe", {31'd0, dut.dq_oe}, 32'd0);
    check("strobes", {28'd0, SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N}, 32'd0);
    rst = 1'b0;
    tick();

    // m0 write 0x10 <- DEADBEEF; inputs scrambled once the request is taken
    m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF;
    push(1'b0, 1'b0, 32'h0);
    tick();
    m0_req = 0; m0_we = 0; m0_addr = 32'h400; m0_wdata = 32'h0;
    for (int i = 0; i < 2 * W; i++) begin
      check("wr_addr", {14'd0, SRAM_ADDR}, (i < W) ? 32'h8 : 32'h9);
      check("wr_dq", {16'd0, SRAM_DQ}, (i < W) ? 32'hBEEF : 32'hDEAD);
      check("wr_we_n", {31'd0, SRAM_WE_N}, 32'd0);
      tick();
    end
    check("done_we_n", {31'd0, SRAM_WE_N}, 32'd1);
    check("done_addr", {14'd0, SRAM_ADDR}, 32'h9);
    tick();
    tick();

    // m1 read back 0x10
    m1_req = 1; m1_addr = 32'h10;
    push(1'b1, 1'b1, 32'hDEADBEEF);
    tick();
    m1_req = 0;
    for (int i = 0; i < 7; i++) tick();

    // Simultaneous requests: m0 first, m1 waits out the transaction
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    m1_req = 1; m1_addr = 32'h20;
    push(1'b0, 1'b1, 32'hDEADBEEF);
    sb.push_back('{port: 1'b1, chk_data: 1'b1, data: 32'hA011A010, cyc: cyc + LAT + 6});
    tick();
    m0_req = 0;
    for (int i = 0; i < 6; i++) tick();
    m1_req = 0;
    for (int i = 0; i < 8; i++) tick();

    // m1 held high: back-to-back reads every 6 cycles
    m1_req = 1; m1_addr = 32'h20;
    for (int k = 0; k < 3; k++) begin
      sb.push_back('{port: 1'b1, chk_data: 1'b1, data: 32'hA011A010, cyc: cyc + LAT + 6 * k});
    end
    for (int i = 0; i < 13; i++) tick();
    m1_req = 0;
    for (int i = 0; i < 8; i++) tick();

    // Reset during the HI phase of a write: no completion
    m0_req = 1; m0_we = 1; m0_addr = 32'h40; m0_wdata = 32'h12345678;
    tick();
    m0_req = 0;
    tick();
    tick();
    check("hi_we_n", {31'd0, SRAM_WE_N}, 32'd0);
    rst = 1'b1;
    tick();
    check("abort_we_n", {31'd0, SRAM_WE_N}, 32'd1);
    check("abort_dq_oe", {31'd0, dut.dq_oe}, 32'd0);
    check("abort_addr", {14'd0, SRAM_ADDR}, 32'd0);
    check("abort_state", {30'd0, dut.state_q}, 32'(arm_sram_pkg::StIdle));
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
